cpc_rom_bank_ctrl: RTL and testbench
====================================

Name: cpc_rom_bank_ctrl

Overview:
CPLD logic for the four-slot upper-ROM expansion board (two 28C256 devices, each holding two 16K slots). It latches the CPC upper-ROM select written to I/O &DFxx and decodes C000-FFFF reads onto the right device and half. It drives ROMDIS (via the board diode) whenever one of its slots answers. It also sequences in-system EEPROM writes: unlock handshake, write-enable pulse and a write-cycle busy timer.

Parameters:
WE_CYCLES, 2, CLK cycles the device WE (socket pin 27) is held low per programmed byte
TWC_CYCLES, 40000, busy cycles after each WE pulse (10 ms at 4 MHz); counter width 16 bits

Ports:
CLK  in  1  CPC 4 MHz system clock
RESET_B  in  1  asynchronous active-low reset
A15, A14, A13  in  1 each  Z80 address bits
D  in  8  Z80 data bus (sampled only)
IOREQ_B, MREQ_B, RD_B, WR_B  in  1 each  Z80 strobes, active low
ROMEN_B  in  1  CPC ROM enable, active low
dip  in  8  dip[7:4] = base ROM number / 4; dip[3:0] = per-slot enable (1 = enabled)
rom01cs_b, rom23cs_b  out  1 each  chip selects for slots 0-1 and 2-3
romoe_b  out  1  shared output enable
roma14  out  1  device A14 (slot LSB)
skt01p27, skt23p27  out  1 each  device WE_B
romdis_pre  out  1  ROMDIS before the diode, active high

Behaviour:
- Reset values: cs/oe/p27 outputs = 1, romdis_pre = 0, roma14 = 0, sel_valid = 0, unlock FSM = IDLE, timer = 0.
- I/O write detect:
  - iow = ~IOREQ_B & ~WR_B & ~A13.
  - iow passes through a 2-flop synchroniser. Its rising edge (first synced-high cycle) is the capture cycle; D is sampled there.
  - Select register updates 3 CLK edges after iow asserts. At most one capture per strobe.
- Slot match:
  - Captured D[7:2] == {2'b00, dip[7:4]} and dip[D[1:0]] == 1 gives sel_valid = 1 and slot = D[1:0].
  - Otherwise sel_valid = 0.
- Read decode (combinational from registered sel/slot):
  - hit = sel_valid & A15 & A14 & ~ROMEN_B.
  - romdis_pre = hit.
  - romoe_b = ~(hit & ~RD_B).
  - rom01cs_b = ~(hit & ~slot[1]); rom23cs_b = ~(hit & slot[1]).
  - roma14 = slot[0] at all times.
- Unlock FSM (captures feed it in order):
  - IDLE -> A5 on capture 0xA5.
  - A5 -> ARM1 on capture 0x5A; any other value -> IDLE.
  - ARM1: next capture is treated as a normal ROM select and also sets wr_armed = sel_valid. FSM -> IDLE.
  - Any later capture clears wr_armed (applying the new select as normal).
  - Captures of 0xA5/0x5A also update the select register; usually no match, so the board goes silent during unlock.
- Write sequencer states: W_IDLE, W_PULSE, W_BUSY.
  - W_IDLE -> W_PULSE when synced memory write (~MREQ_B & ~WR_B, 2-flop, rising edge) & A15 & A14 & wr_armed & sel_valid.
  - W_PULSE: selected cs_b = 0 and selected p27 = 0 for exactly WE_CYCLES cycles; roma14 = slot[0]; romoe_b held 1. The CPU must keep WR_B/D stable (CPC write cycle ≥ 3 CLK covers WE_CYCLES = 2).
  - W_PULSE -> W_BUSY; load timer = TWC_CYCLES-1.
  - W_BUSY: memory writes are ignored. Reads still decode normally (data polling). Timer reaching 0 -> W_IDLE.
  - A select change during BUSY does not abort the timer.
- Simultaneous read hit during W_PULSE cannot occur on Z80; if it does, the write takes priority.
- RESET_B low at any time: immediate return to reset values, including p27 forced high mid-pulse.

Optional Feature:
CPC_ROM_WRITE_EN
- Defined: unlock FSM, wr_armed, write sequencer and timer are present as described.
- Undefined: that logic is removed; skt01p27 = skt23p27 = 1 constantly; captures affect only the select register.

Test Plan:
- dip = 8'h3F (base 12, all slots enabled); IO write &DF00 D = 0x0E; read C000 with ROMEN_B low -> rom23cs_b = 0, roma14 = 0, romoe_b = 0, romdis_pre = 1, rom01cs_b = 1.
- dip = 8'h3D (slot 1 disabled); select 0x0D -> no cs/oe/romdis on C000 reads. Select 0x0C -> rom01cs_b = 0, roma14 = 0. A15:A14 = 10 read -> all outputs inactive.
- Select latency: iow asserted at edge N -> new select visible at edge N+3. A strobe held 5 cycles -> single capture.
- With _EN, dip = 8'h3F: writes 0xA5, 0x5A, 0x0D, then memory write to C123 -> skt01p27 low exactly 2 cycles, rom01cs_b low, roma14 = 1. A second write within 40000 cycles -> no pulse. After timeout, the next write pulses again.
- Unlock broken: 0xA5, 0x00, 0x5A, 0x0D then memory write -> no p27 pulse. Armed then select 0x0C -> disarmed, no pulse.
- Assert RESET_B during W_PULSE -> p27 high immediately, sel_valid = 0, timer cleared. Without _EN, the armed sequence produces p27 = 1 throughout.

Source files
------------

// File: rtl/cpc_rom_bank_ctrl_if.sv
// ============================================================================
//  Module      : cpc_rom_bank_ctrl_if
//  Description : Z80/CPC bus and ROM-socket signal bundle for the four-slot
//                upper-ROM expansion board controller.
//                master = CPU/board side, slave = cpc_rom_bank_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpc_rom_bank_ctrl_if;
    // Z80 side
    logic       A15;
    logic       A14;
    logic       A13;
    logic [7:0] D;
    logic       IOREQ_B;
    logic       MREQ_B;
    logic       RD_B;
    logic       WR_B;
    logic       ROMEN_B;
    // Board configuration switches
    logic [7:0] dip;
    // ROM socket side
    logic       rom01cs_b;
    logic       rom23cs_b;
    logic       romoe_b;
    logic       roma14;
    logic       skt01p27;
    logic       skt23p27;
    logic       romdis_pre;

    modport master (
        output A15, A14, A13, D, IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B, dip,
        input  rom01cs_b, rom23cs_b, romoe_b, roma14, skt01p27, skt23p27,
               romdis_pre
    );

    modport slave (
        input  A15, A14, A13, D, IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B, dip,
        output rom01cs_b, rom23cs_b, romoe_b, roma14, skt01p27, skt23p27,
               romdis_pre
    );
endinterface

`default_nettype wire

// File: rtl/cpc_rom_bank_ctrl.sv
// ============================================================================
//  Module      : cpc_rom_bank_ctrl
//  Description : Upper-ROM bank controller for a four-slot board built from
//                two 28C256 devices (two 16K slots each). Latches the ROM
//                select written to I/O &DFxx, decodes C000-FFFF reads onto
//                the right device/half and raises ROMDIS when a slot answers.
//                Optional feature macro CPC_ROM_WRITE_EN adds the EEPROM
//                unlock handshake, WE pulse generator and write-cycle timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpc_rom_bank_ctrl #(
    parameter int WE_CYCLES  = 2,
    parameter int TWC_CYCLES = 40000
) (
    input wire CLK,
    input wire RESET_B,
    cpc_rom_bank_ctrl_if.slave bus
);

    // ------------------------------------------------------------------
    // I/O write detect: &DFxx is decoded by A13 low alone, as on the CPC.
    // ------------------------------------------------------------------
    logic iow;
    logic iow_s1_q;
    logic iow_s2_q;
    logic iow_prev_q;
    logic capture;
    logic match;

    assign iow = ~bus.IOREQ_B & ~bus.WR_B & ~bus.A13;

    // Two-flop synchroniser for the I/O write strobe plus a history flop for edge detection
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            iow_s1_q   <= 1'b0;
            iow_s2_q   <= 1'b0;
            iow_prev_q <= 1'b0;
        end else begin
            iow_s1_q   <= iow;
            iow_s2_q   <= iow_s1_q;
            iow_prev_q <= iow_s2_q;
        end
    end

    // Only the first synced-high cycle captures, so a long strobe latches once.
    assign capture = iow_s2_q & ~iow_prev_q;

    // A slot answers when the written ROM number falls in this board's block
    // of four and that slot's enable switch is on.
    assign match = (bus.D[7:2] == {2'b00, bus.dip[7:4]}) & bus.dip[bus.D[1:0]];

    // ------------------------------------------------------------------
    // Select register
    // ------------------------------------------------------------------
    logic       sel_valid_q;
    logic [1:0] slot_q;

    // Latch the decoded select on each capture; slot keeps the last matching value
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sel_valid_q <= 1'b0;
            slot_q      <= 2'b00;
        end else if (capture) begin
            sel_valid_q <= match;
            if (match) begin
                slot_q <= bus.D[1:0];
            end
        end
    end

    // Read hit: upper 16K, CPC asking for an upper ROM, and one of our slots selected.
    logic hit;
    assign hit = sel_valid_q & bus.A15 & bus.A14 & ~bus.ROMEN_B;

    // High while the WE pulse to the selected device is active.
    logic pulse;

`ifdef CPC_ROM_WRITE_EN
    // ------------------------------------------------------------------
    // Unlock handshake: 0xA5, 0x5A, then a select that arms writing.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        U_IDLE = 2'd0,
        U_A5   = 2'd1,
        U_ARM1 = 2'd2
    } ul_state_t;

    ul_state_t ul_q;
    ul_state_t ul_d;
    logic      wr_armed_q;
    logic      wr_armed_d;

    // Unlock state and arm flag registers
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            ul_q       <= U_IDLE;
            wr_armed_q <= 1'b0;
        end else begin
            ul_q       <= ul_d;
            wr_armed_q <= wr_armed_d;
        end
    end

    // Every capture disarms unless it is the select that completes the handshake
    always_comb begin
        ul_d       = ul_q;
        wr_armed_d = wr_armed_q;
        if (capture) begin
            ul_d       = U_IDLE;
            wr_armed_d = 1'b0;
            case (ul_q)
                U_IDLE: begin
                    if (bus.D == 8'hA5) begin
                        ul_d = U_A5;
                    end
                end
                U_A5: begin
                    if (bus.D == 8'h5A) begin
                        ul_d = U_ARM1;
                    end
                end
                U_ARM1: begin
                    wr_armed_d = match;
                end
                default: begin
                    ul_d = U_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory write detect
    // ------------------------------------------------------------------
    logic mw;
    logic mw_s1_q;
    logic mw_s2_q;
    logic mw_prev_q;
    logic mw_rise;

    assign mw = ~bus.MREQ_B & ~bus.WR_B;

    // Two-flop synchroniser for the memory write strobe plus edge history
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            mw_s1_q   <= 1'b0;
            mw_s2_q   <= 1'b0;
            mw_prev_q <= 1'b0;
        end else begin
            mw_s1_q   <= mw;
            mw_s2_q   <= mw_s1_q;
            mw_prev_q <= mw_s2_q;
        end
    end

    assign mw_rise = mw_s2_q & ~mw_prev_q;

    // ------------------------------------------------------------------
    // Write sequencer: WE pulse, then device write-cycle busy time.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_PULSE = 2'd1,
        W_BUSY  = 2'd2
    } wr_state_t;

    localparam logic [7:0]  c_WE_LOAD  = 8'(WE_CYCLES - 1);
    localparam logic [15:0] c_TWC_LOAD = 16'(TWC_CYCLES - 1);

    wr_state_t   wr_q;
    wr_state_t   wr_d;
    logic [7:0]  we_cnt_q;
    logic [7:0]  we_cnt_d;
    logic [15:0] timer_q;
    logic [15:0] timer_d;

    // Sequencer state, pulse counter and busy timer registers
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            wr_q     <= W_IDLE;
            we_cnt_q <= 8'd0;
            timer_q  <= 16'd0;
        end else begin
            wr_q     <= wr_d;
            we_cnt_q <= we_cnt_d;
            timer_q  <= timer_d;
        end
    end

    // Start a pulse on an armed upper-16K write; busy time cannot be cut short
    always_comb begin
        wr_d     = wr_q;
        we_cnt_d = we_cnt_q;
        timer_d  = timer_q;
        case (wr_q)
            W_IDLE: begin
                if (mw_rise & bus.A15 & bus.A14 & wr_armed_q & sel_valid_q) begin
                    wr_d     = W_PULSE;
                    we_cnt_d = c_WE_LOAD;
                end
            end
            W_PULSE: begin
                if (we_cnt_q == 8'd0) begin
                    wr_d    = W_BUSY;
                    timer_d = c_TWC_LOAD;
                end else begin
                    we_cnt_d = we_cnt_q - 8'd1;
                end
            end
            W_BUSY: begin
                if (timer_q == 16'd0) begin
                    wr_d = W_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                wr_d = W_IDLE;
            end
        endcase
    end

    assign pulse = (wr_q == W_PULSE);
`else
    // Read-only build: no write path, captures only touch the select register.
    logic unused_mreq;
    localparam int unused_cfg = WE_CYCLES + TWC_CYCLES;
    assign unused_mreq = bus.MREQ_B;
    assign pulse       = 1'b0;
`endif

    // Socket drive: read decode by default, the write pulse overrides it
    always_comb begin
        bus.romdis_pre = hit;
        bus.roma14     = slot_q[0];
        bus.romoe_b    = ~(hit & ~bus.RD_B);
        bus.rom01cs_b  = ~(hit & ~slot_q[1]);
        bus.rom23cs_b  = ~(hit &  slot_q[1]);
        bus.skt01p27   = 1'b1;
        bus.skt23p27   = 1'b1;
        if (pulse) begin
            bus.romoe_b   = 1'b1;
            bus.rom01cs_b = slot_q[1];
            bus.rom23cs_b = ~slot_q[1];
            bus.skt01p27  = slot_q[1];
            bus.skt23p27  = ~slot_q[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpc_rom_bank_ctrl.sv
// ============================================================================
//  Module      : tb_cpc_rom_bank_ctrl
//  Description : Self-checking bench for cpc_rom_bank_ctrl with a behavioural
//                model of select decoding and the unlock handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpc_rom_bank_ctrl;

    logic CLK = 1'b0;
    logic RESET_B = 1'b0;
    always #5 CLK = ~CLK;

    cpc_rom_bank_ctrl_if bus();

    cpc_rom_bank_ctrl #(
        .WE_CYCLES (2),
        .TWC_CYCLES(40000)
    ) dut (
        .CLK    (CLK),
        .RESET_B(RESET_B),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: history of captured bytes and whether each matched at capture time.
    logic [7:0] hist[$];
    bit         hist_match[$];
    bit         m_valid;
    int         m_slot;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist_match.delete();
        m_valid = 1'b0;
        m_slot  = 0;
    endtask

    task automatic model_capture(input logic [7:0] d, input logic [7:0] dp);
        bit ok;
        ok = (int'(d) / 4 == int'(dp) / 16) && dp[int'(d) % 4];
        hist.push_back(d);
        hist_match.push_back(ok);
        m_valid = ok;
        if (ok) m_slot = int'(d) % 4;
    endtask

    // Walk the capture history: A5,5A,X arms iff X matched; anything after disarms.
    function automatic bit model_armed();
        int i = 0;
        int n = hist.size();
        bit armed = 1'b0;
        while (i < n) begin
            armed = 1'b0;
            if (hist[i] == 8'hA5 && i + 1 < n) begin
                if (hist[i+1] == 8'h5A && i + 2 < n) begin
                    armed = hist_match[i+2];
                    i += 3;
                end else begin
                    i += 2;
                end
            end else begin
                i += 1;
            end
        end
        return armed;
    endfunction

    task automatic bus_idle();
        bus.IOREQ_B = 1'b1; bus.MREQ_B = 1'b1; bus.RD_B = 1'b1; bus.WR_B = 1'b1;
        bus.ROMEN_B = 1'b1; bus.A15 = 1'b0; bus.A14 = 1'b0; bus.A13 = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] d);
        @(negedge CLK);
        bus.A15 = 1'b1; bus.A14 = 1'b1; bus.A13 = 1'b0; bus.D = d;
        bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
        repeat (4) @(negedge CLK);
        bus_idle();
        repeat (2) @(negedge CLK);
        model_capture(d, bus.dip);
    endtask

    task automatic read_check(input string tag, input logic a15, input logic a14,
                              input logic romen_b, input logic rd_b);
        bit   h;
        logic [7:0] exp;
        @(negedge CLK);
        bus.A15 = a15; bus.A14 = a14; bus.A13 = 1'b1; bus.ROMEN_B = romen_b;
        bus.RD_B = rd_b; bus.MREQ_B = 1'b0;
        #1;
        h   = m_valid && a15 && a14 && !romen_b;
        exp = {4'b0, !(h && m_slot < 2), !(h && m_slot >= 2), !(h && !rd_b), h};
        check(tag, {4'b0, bus.rom01cs_b, bus.rom23cs_b, bus.romoe_b, bus.romdis_pre}, exp);
        if (m_valid) check({tag, "_a14"}, {7'b0, bus.roma14}, 8'(m_slot % 2));
        check({tag, "_p27"}, {6'b0, bus.skt01p27, bus.skt23p27}, 8'h03);
        bus_idle();
    endtask

    // Memory write to C123; counts WE-low cycles per socket and snapshots the pulse.
    task automatic mem_write(output int lows01, output int lows23, output logic [2:0] snap);
        @(negedge CLK);
        bus.A15 = 1'b1; bus.A14 = 1'b1; bus.A13 = 1'b0; bus.D = 8'h55;
        bus.ROMEN_B = 1'b1; bus.MREQ_B = 1'b0; bus.WR_B = 1'b0;
        lows01 = 0; lows23 = 0; snap = 3'b111;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.skt01p27 == 1'b0) begin
                lows01++;
                snap = {bus.rom01cs_b, bus.roma14, bus.romoe_b};
            end
            if (bus.skt23p27 == 1'b0) lows23++;
            if (i == 5) bus_idle();
        end
        bus_idle();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_B = 1'b0;
        @(negedge CLK);
        RESET_B = 1'b1;
        model_reset();
    endtask

    initial begin
        int         l01;
        int         l23;
        logic [2:0] snap;
        logic [7:0] dp;
        logic [7:0] d;
        bit         seen;

        model_reset();
        bus_idle();
        bus.D = 8'h00; bus.dip = 8'h3F;
        // Reset state with a would-be hit presented on the bus.
        bus.A15 = 1'b1; bus.A14 = 1'b1; bus.ROMEN_B = 1'b0; bus.RD_B = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {1'b0, bus.rom01cs_b, bus.rom23cs_b, bus.romoe_b, bus.roma14,
              bus.skt01p27, bus.skt23p27, bus.romdis_pre}, 8'b0111_0110);
        @(negedge CLK);
        RESET_B = 1'b1;
        bus_idle();

        // Select latency: strobe driven before edge 1, select visible after edge 3.
        @(negedge CLK);
        bus.A15 = 1'b1; bus.A14 = 1'b1; bus.A13 = 1'b0; bus.ROMEN_B = 1'b0;
        bus.D = 8'h0E; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
        repeat (2) @(posedge CLK);
        #1 check("latency_edge2", {7'b0, bus.romdis_pre}, 8'h00);
        @(posedge CLK);
        #1 check("latency_edge3", {7'b0, bus.romdis_pre}, 8'h01);
        bus.D = 8'h0C;                         // must not be captured: same strobe
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        bus_idle();
        model_capture(8'h0E, 8'h3F);
        repeat (2) @(negedge CLK);
        read_check("sel_0E_C000", 1'b1, 1'b1, 1'b0, 1'b0);
        read_check("sel_0E_C000_nord", 1'b1, 1'b1, 1'b0, 1'b1);

        // Disabled slot, enabled slot, and an address outside C000-FFFF.
        bus.dip = 8'h3D;
        io_write(8'h0D);
        read_check("slot1_disabled", 1'b1, 1'b1, 1'b0, 1'b0);
        io_write(8'h0C);
        read_check("slot0_C000", 1'b1, 1'b1, 1'b0, 1'b0);
        read_check("slot0_8000", 1'b1, 1'b0, 1'b0, 1'b0);
        read_check("slot0_romen_hi", 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomised selects and reads against the model.
        for (int k = 0; k < 16; k++) begin
            dp = 8'($urandom);
            if ($urandom_range(3, 0) != 0) d = {2'b00, dp[7:4], 2'($urandom)};
            else                           d = 8'($urandom);
            bus.dip = dp;
            io_write(d);
            read_check("rand_read_a", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            read_check("rand_read_b", 1'b1, 1'b1, 1'b0, 1'($urandom));
        end

`ifdef CPC_ROM_WRITE_EN
        do_reset();
        bus.dip = 8'h3F;
        // Broken handshake.
        io_write(8'hA5); io_write(8'h00); io_write(8'h5A); io_write(8'h0D);
        mem_write(l01, l23, snap);
        check("broken_unlock", 8'(l01 + l23), (model_armed() && m_valid) ? 8'd2 : 8'd0);
        // Armed then reselected.
        io_write(8'hA5); io_write(8'h5A); io_write(8'h0D); io_write(8'h0C);
        mem_write(l01, l23, snap);
        check("disarmed_by_select", 8'(l01 + l23), model_armed() ? 8'd2 : 8'd0);
        // Proper unlock and programming pulse.
        io_write(8'hA5); io_write(8'h5A); io_write(8'h0D);
        mem_write(l01, l23, snap);
        check("pulse_len", 8'(l01), (model_armed() && m_valid) ? 8'd2 : 8'd0);
        check("pulse_other_skt", 8'(l23), 8'd0);
        check("pulse_cs_a14_oe", {5'b0, snap}, 8'b0000_0011);
        // Busy: the next write is ignored.
        mem_write(l01, l23, snap);
        check("busy_no_pulse", 8'(l01 + l23), 8'd0);
        read_check("busy_read", 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (40000) @(negedge CLK);
        // After timeout a write pulses again; reset lands in the middle of it.
        @(negedge CLK);
        bus.A15 = 1'b1; bus.A14 = 1'b1; bus.A13 = 1'b0; bus.ROMEN_B = 1'b0;
        bus.MREQ_B = 1'b0; bus.WR_B = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (bus.skt01p27 == 1'b0) seen = 1'b1;
        end
        check("pulse_after_timeout", {7'b0, seen}, 8'h01);
        #2 RESET_B = 1'b0;
        #1;
        check("reset_mid_pulse", {5'b0, bus.skt01p27, bus.rom01cs_b, bus.romdis_pre}, 8'b0000_0110);
        @(negedge CLK);
        bus_idle();
        RESET_B = 1'b1;
        model_reset();
        read_check("sel_cleared", 1'b1, 1'b1, 1'b0, 1'b0);
        io_write(8'hA5); io_write(8'h5A); io_write(8'h0D);
        mem_write(l01, l23, snap);
        check("timer_cleared", 8'(l01), 8'd2);
`else
        do_reset();
        bus.dip = 8'h3F;
        io_write(8'hA5); io_write(8'h5A); io_write(8'h0D);
        mem_write(l01, l23, snap);
        check("no_write_path", 8'(l01 + l23), 8'd0);
        read_check("readonly_select", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
